// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared defaults and FSM state type for the DataMem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_ADDR_W_DEF     = 10;
    localparam int c_DATA_W_DEF     = 32;
    localparam int c_STARVE_MAX_DEF = 4;

    // State names what the DataMem did in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2,
        WR     = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pick
// Purpose  : Combinational CPU/debug winner select with optional starvation
//            guard (enabled by macro DMEM_ARB_FAIRNESS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = c_STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dbg_req,
    output logic cpu_gnt,
    output logic dbg_gnt
);

    logic w_force;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    logic [c_CNT_W-1:0] r_starve;

    assign w_force = (r_starve == c_CNT_W'(STARVE_MAX));

    // Clears whenever debug is served or stops asking; a forced grant
    // therefore also clears it, so the count never passes STARVE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            r_starve <= '0;
        end else begin
            r_starve <= r_starve + c_CNT_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    assign w_force      = 1'b0;
    assign w_unused_cfg = clk ^ (STARVE_MAX == 0);
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (dbg_req && (!cpu_req || w_force)) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Single-port DataMem arbiter between the MEM stage and a debug
//            port; fairness guard enabled by macro DMEM_ARB_FAIRNESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W_DEF,
    parameter int DATA_W     = c_DATA_W_DEF,
    parameter int STARVE_MAX = c_STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    arb_state_t        r_state;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .cpu_gnt (w_cpu_gnt),
        .dbg_gnt (w_dbg_gnt)
    );

    always_comb begin
        mem_en    = w_cpu_gnt | w_dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign cpu_stall = cpu_req & ~w_cpu_gnt & ~rst;
    assign dbg_gnt   = w_dbg_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_cpu_gnt) begin
            r_state <= cpu_we ? WR : CPU_RD;
        end else if (w_dbg_gnt) begin
            r_state <= dbg_we ? WR : DBG_RD;
        end else begin
            r_state <= IDLE;
        end
    end

    // Capture returning data so each port keeps its last read between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (r_state == CPU_RD) r_cpu_rdata <= mem_rdata;
            if (r_state == DBG_RD) r_dbg_rdata <= mem_rdata;
        end
    end

    // Gated by rst so a read issued just before reset never reports valid.
    assign cpu_rvalid = ~rst & (r_state == CPU_RD);
    assign dbg_rvalid = ~rst & (r_state == DBG_RD);
    assign cpu_rdata  = rst ? '0 : ((r_state == CPU_RD) ? mem_rdata : r_cpu_rdata);
    assign dbg_rdata  = rst ? '0 : ((r_state == DBG_RD) ? mem_rdata : r_dbg_rdata);

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_W, 10, word-address width; DATA_W, 32, data width; STARVE_MAX, 4, consecutive stalled-debug cycles before forced debug grant.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM-stage access request.
- cpu_we  in  1  MEM-stage write (1) / read (0).
- cpu_addr  in  ADDR_W  MEM-stage word address (ALU_out>>2).
- cpu_wdata  in  DATA_W  MEM-stage store data.
- cpu_stall  out  1  freeze pipeline; CPU request not served this cycle.
- cpu_rdata  out  DATA_W  load data.
- cpu_rvalid  out  1  cpu_rdata valid.
- dbg_req  in  1  debug/result-dump port request.
- dbg_we, dbg_addr, dbg_wdata  in  1/ADDR_W/DATA_W  debug access fields.
- dbg_gnt  out  1  debug request served this cycle.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_rvalid  out  1  dbg_rdata valid.
- mem_en, mem_we  out  1  single-port DataMem strobes.
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  DataMem address and data.
- mem_rdata  in  DATA_W  DataMem read data, one cycle after a read strobe.

Function
REQ-003 The block SHALL issue at most one DataMem access per cycle.
REQ-004 Winner selection SHALL be combinational within the cycle; mem_* SHALL carry the winner's fields, with mem_en=0 and mem_we=0 when no request is pending.
REQ-005 Default priority: CPU wins on simultaneous requests; debug wins only when cpu_req=0.
REQ-006 cpu_stall SHALL equal cpu_req AND NOT cpu-granted; dbg_gnt SHALL equal dbg_req AND debug-granted.
REQ-007 Requesters SHALL hold req and fields stable until served; the arbiter SHALL NOT latch losing requests.
REQ-008 Read data latency SHALL be one cycle: owner register records the reader; next cycle cpu_rvalid or dbg_rvalid =1 and the matching rdata = mem_rdata.
REQ-009 Writes SHALL produce no rvalid.
REQ-010 The non-owner rdata output SHALL hold its last value; an rdata output is meaningful only while its rvalid is high.
REQ-011 Back-to-back reads by the same or alternating requesters SHALL sustain one access per cycle with no bubble.
REQ-012 FSM states: IDLE (no access last cycle), CPU_RD, DBG_RD, WR. Next state follows the current cycle's grant and we. rvalid decodes from the current state.
REQ-013 A write followed by a read of the same address SHALL return the new data; ordering is preserved because only one access is issued per cycle.

Reset
REQ-014 While rst=1: state=IDLE, starve counter=0, cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
REQ-015 While rst=1, mem_en=0, mem_we=0, cpu_stall=0 and dbg_gnt=0, regardless of requests.
REQ-016 A read granted in the cycle before rst asserts SHALL NOT produce an rvalid after reset.

Configuration
REQ-017 Macro DMEM_ARB_FAIRNESS_EN, when defined, adds a starve counter. The counter increments each cycle dbg_req=1 and dbg_gnt=0, and clears on dbg_gnt or dbg_req=0. When the counter equals STARVE_MAX, debug wins the next arbitration, cpu_stall asserts, and the counter clears.
REQ-018 Without DMEM_ARB_FAIRNESS_EN the counter does not exist and REQ-005 strict CPU priority applies; debug may starve indefinitely.

Structure
REQ-019 Shared package dmem_arb_pkg SHALL hold the default ADDR_W/DATA_W/STARVE_MAX constants and the FSM state typedef (IDLE, CPU_RD, DBG_RD, WR).
REQ-020 The winner-select and fairness logic SHALL live in a sub-module dmem_arb_pick; the FSM and rdata/rvalid registers stay in dmem_arbiter.

Verification
REQ-021 CPU read addr 0x100, dbg idle -> mem_en=1, mem_addr=0x100, cpu_stall=0; next cycle cpu_rvalid=1 and cpu_rdata = DataMem[0x100].
REQ-022 Simultaneous CPU write 0x104 = 0xDEADBEEF and debug read 0x104 -> cycle 1: CPU wins and dbg_gnt=0. Cycle 2: debug granted. Cycle 3: dbg_rvalid=1, dbg_rdata=0xDEADBEEF.
REQ-023 Debug-only reads 0x100..0x104 on consecutive cycles -> dbg_gnt=1 each cycle; dbg_rvalid=1 for 5 consecutive cycles, data in address order.
REQ-024 With DMEM_ARB_FAIRNESS_EN and STARVE_MAX=4, cpu_req and dbg_req held high -> CPU served 4 cycles; 5th cycle dbg_gnt=1 and cpu_stall=1. Without the macro: cpu_stall=0 and dbg_gnt=0 throughout.
REQ-025 CPU read granted, rst=1 on the next edge -> cpu_rvalid=0 and mem_en=0 throughout reset; state=IDLE after release.
